// File: rtl/mem_port_arbiter_if.sv
// CACHE request-type package and the lane/cache bus bundle used by mem_port_arbiter.
// slave is the arbiter's view of the bus; master is the view of the lanes and D-cache around it.
package CACHE;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } req_type;
endpackage

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  import CACHE::*;

  req_type             l0_req_type;
  logic [ADDR_W-1:0]   l0_req_addr;
  logic [DATA_W-1:0]   l0_req_data;
  logic                l0_respcyc;
  req_type             l1_req_type;
  logic [ADDR_W-1:0]   l1_req_addr;
  logic [DATA_W-1:0]   l1_req_data;
  logic                l1_respcyc;
  logic [DATA_W-1:0]   lane_resp_data;
  req_type             cache_req_type;
  logic [ADDR_W-1:0]   cache_req_addr;
  logic [DATA_W-1:0]   cache_req_data;
  logic                mem_respcyc;
  logic [DATA_W-1:0]   resp_data;
  logic [1:0]          grant;
  logic                arb_busy;
  logic                timeout_err;

  modport slave (
    input  l0_req_type, l0_req_addr, l0_req_data,
    input  l1_req_type, l1_req_addr, l1_req_data,
    input  mem_respcyc, resp_data,
    output l0_respcyc, l1_respcyc, lane_resp_data,
    output cache_req_type, cache_req_addr, cache_req_data,
    output grant, arb_busy, timeout_err
  );

  modport master (
    output l0_req_type, l0_req_addr, l0_req_data,
    output l1_req_type, l1_req_addr, l1_req_data,
    output mem_respcyc, resp_data,
    input  l0_respcyc, l1_respcyc, lane_resp_data,
    input  cache_req_type, cache_req_addr, cache_req_data,
    input  grant, arb_busy, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single D-cache request port shared by the two mem pipeline lanes.
// Define ARB_TIMEOUT_EN to build the ownership watchdog that raises the sticky timeout_err.
module mem_port_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  import CACHE::*;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  arb_state_e state;
  arb_state_e state_next;
  logic       last_grant;
  logic       last_grant_next;
  logic       req0;
  logic       req1;
  logic       owner_req;
  logic       timeout_hit;

  assign req0      = (bus.l0_req_type != IDLE);
  assign req1      = (bus.l1_req_type != IDLE);
  assign owner_req = (state == ARB_OWN0) ? req0 : req1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // A grant lasts until the cache responds; the response cycle can hand off directly to the waiting lane.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    unique case (state)
      ARB_IDLE: begin
        if (req0 && req1) begin
          state_next = last_grant ? ARB_OWN0 : ARB_OWN1;
        end else if (req0) begin
          state_next = ARB_OWN0;
        end else if (req1) begin
          state_next = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        if (bus.mem_respcyc) begin
          last_grant_next = 1'b0;
          state_next      = req1 ? ARB_OWN1 : ARB_IDLE;
        end else if (!req0 || timeout_hit) begin
          state_next = ARB_IDLE;
        end
      end
      ARB_OWN1: begin
        if (bus.mem_respcyc) begin
          last_grant_next = 1'b1;
          state_next      = req0 ? ARB_OWN0 : ARB_IDLE;
        end else if (!req1 || timeout_hit) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.cache_req_type = IDLE;
    bus.cache_req_addr = '0;
    bus.cache_req_data = '0;
    bus.l0_respcyc     = 1'b0;
    bus.l1_respcyc     = 1'b0;
    bus.lane_resp_data = bus.resp_data;
    bus.grant          = 2'b00;
    bus.arb_busy       = 1'b0;
    unique case (state)
      ARB_OWN0: begin
        bus.grant          = 2'b01;
        bus.arb_busy       = 1'b1;
        bus.cache_req_type = bus.l0_req_type;
        bus.cache_req_addr = bus.l0_req_addr;
        bus.cache_req_data = bus.l0_req_data;
        bus.l0_respcyc     = bus.mem_respcyc;
      end
      ARB_OWN1: begin
        bus.grant          = 2'b10;
        bus.arb_busy       = 1'b1;
        bus.cache_req_type = bus.l1_req_type;
        bus.cache_req_addr = bus.l1_req_addr;
        bus.cache_req_data = bus.l1_req_data;
        bus.l1_respcyc     = bus.mem_respcyc;
      end
      default: ;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] wd_count;
  logic        timeout_q;

  // The watchdog counts owned cycles without a response; a withdrawn owner is not a timeout.
  assign timeout_hit = (state != ARB_IDLE) && !bus.mem_respcyc && owner_req &&
                       (wd_count == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_count  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_next != state) begin
        wd_count <= '0;
      end else if ((state != ARB_IDLE) && !bus.mem_respcyc) begin
        wd_count <= wd_count + 16'd1;
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single cache request port between the two memory-pipeline lanes of the superscalar back end.
- Each lane presents a held request (CACHE::req_type, address, data) and waits for its own respcyc.
- The arbiter grants one lane at a time, round-robin, and holds the grant until the cache returns mem_respcyc.
- Sits between the two mem pipelines and the D-cache.

Parameters:
- ADDR_W, 64, request address width.
- DATA_W, 64, request and response data width.
- TIMEOUT_CYCLES, 1023, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- l0_req_type  input  CACHE::req_type  lane 0 request; IDLE means no request.
- l0_req_addr  input  ADDR_W  lane 0 address.
- l0_req_data  input  DATA_W  lane 0 store data.
- l0_respcyc  output  1  lane 0 response strobe.
- l1_req_type  input  CACHE::req_type  lane 1 request.
- l1_req_addr  input  ADDR_W  lane 1 address.
- l1_req_data  input  DATA_W  lane 1 store data.
- l1_respcyc  output  1  lane 1 response strobe.
- lane_resp_data  output  DATA_W  response data, broadcast to both lanes.
- cache_req_type  output  CACHE::req_type  request to the cache.
- cache_req_addr  output  ADDR_W  address to the cache.
- cache_req_data  output  DATA_W  data to the cache.
- mem_respcyc  input  1  cache response strobe.
- resp_data  input  DATA_W  cache response data.
- grant  output  2  one-hot current owner; bit0 = lane 0.
- arb_busy  output  1  a transaction is outstanding.
- timeout_err  output  1  sticky watchdog error.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=ARB_IDLE, last_grant=1 (so lane 0 wins first), grant=0, arb_busy=0, timeout_err=0.
  - cache_req_type=IDLE, cache_req_addr=0, cache_req_data=0.
  - l0_respcyc=0, l1_respcyc=0.
- States: ARB_IDLE, ARB_OWN0, ARB_OWN1. grant and arb_busy are decoded from the registered state.
- ARB_IDLE:
  - cache_req_type=IDLE; addr and data are 0.
  - If only lane k requests (req_type!=IDLE), next state is ARB_OWNk.
  - If both request, the lane != last_grant wins.
  - If neither requests, stay in ARB_IDLE.
- Latency: a request first seen in cycle N reaches the cache in cycle N+1.
  - The lane holds its request stable until its respcyc; the lane pipeline already does this.
- ARB_OWNk:
  - Cache port outputs are combinationally muxed from lane k.
  - lk_respcyc = mem_respcyc; the other lane's respcyc is forced to 0, so that lane stays stalled.
  - lane_resp_data = resp_data at all times.
  - On mem_respcyc: last_grant<=k. Next state is ARB_OWN(other) if the other lane requests that cycle, else ARB_IDLE.
  - No back-to-back re-grant to the same lane: its request in the response cycle is the old one.
- Owner withdraws (lk_req_type==IDLE while in ARB_OWNk without mem_respcyc): protocol error.
  - Next state ARB_IDLE; last_grant is unchanged; no respcyc is issued.
- mem_respcyc while in ARB_IDLE: ignored; no respcyc to any lane.
- Lane requests that change while the lane is not granted are don't-care until granted. They are sampled only at arbitration.
- Fairness: under continuous requests from both lanes, grants alternate 0,1,0,1.
  - Worst-case wait for a lane is one complete transaction of the other lane.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on every transition into ARB_OWNk and increments each cycle while in ARB_OWNk without mem_respcyc.
  - When the count reaches TIMEOUT_CYCLES: timeout_err<=1 (sticky until reset), next state ARB_IDLE, no respcyc to the owner.
  - A later mem_respcyc arriving in ARB_IDLE is ignored.
- ARB_TIMEOUT_EN undefined: no counter is built, timeout_err is tied to 0, and a grant is held indefinitely.

Test Plan:
- Reset mid-transaction:
  - Stimulus: lane 0 READ addr 0x1000; grant=01 in cycle 1; reset pulled low in cycle 3.
  - Response: immediately grant=0, cache_req_type=IDLE, l0_respcyc=0.
  - After release, the held READ is re-granted on the first cycle.
- Single lane:
  - Stimulus: lane 1 WRITE addr 0x2008 data 0xDEADBEEF; cache responds 4 cycles later.
  - Response: the cache sees WRITE/0x2008/0xDEADBEEF from cycle N+1; l1_respcyc=1 exactly in the response cycle; l0_respcyc stays 0.
- Simultaneous first request:
  - Stimulus: both lanes request after reset.
  - Response: lane 0 granted first; lane 1 granted in the cycle after lane 0's respcyc, with no IDLE cycle between them.
- Sustained contention:
  - Stimulus: both lanes hold requests continuously for 6 transactions with a 2-cycle cache latency.
  - Response: grant sequence 01,10,01,10,01,10; each lane receives exactly 3 respcyc.
- Spurious response and withdrawal:
  - Stimulus: mem_respcyc pulsed while in ARB_IDLE; separately, the owner drops to IDLE mid-grant.
  - Response: no respcyc on either lane; the arbiter returns to ARB_IDLE; last_grant is unchanged.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: lane 0 READ with no cache response.
  - Response: timeout_err=1 after 8 owned cycles; state ARB_IDLE; timeout_err stays 1 until reset.
